picorv_uart_runner: RTL and testbench
=====================================

PICORV_UART_RUNNER -- requirements
Module: picorv_uart_runner

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 434, giving clock cycles per UART bit.
REQ-002 SHALL have parameter MEM_BYTES, default 256, giving the byte-image depth (power of two, 2..4096).
REQ-003 SHALL have port clk_i, input, 1 bit: the single clock. All logic is on its rising edge.
REQ-004 SHALL have port rst_i, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port mem_we_i, input, 1 bit: image write strobe.
REQ-006 SHALL have port mem_addr_i, input, $clog2(MEM_BYTES) bits: image write address.
REQ-007 SHALL have port mem_wdata_i, input, 8 bits: image write data.
REQ-008 SHALL have port len_i, input, $clog2(MEM_BYTES)+1 bits: number of bytes per pass.
REQ-009 SHALL have port repeat_i, input, 8 bits: number of passes.
REQ-010 SHALL have port start_i, input, 1 bit: run request.
REQ-011 SHALL have port busy_o, output, 1 bit: a run is in progress.
REQ-012 SHALL have port done_o, output, 1 bit: one-cycle run-complete pulse.
REQ-013 SHALL have port uart_tx_o, output, 1 bit: serial line, idle high.

Function
REQ-014 SHALL write mem_wdata_i to byte mem_addr_i when mem_we_i=1 and busy_o=0. Writes while busy SHALL be ignored.
REQ-015 SHALL use states IDLE, SEND, NEXT, DONE. IDLE->SEND on start_i=1 with len_i!=0 and repeat_i!=0. SEND->NEXT at the end of a stop bit. NEXT->SEND while bytes remain. NEXT->DONE after the last byte of the last pass. DONE->IDLE after exactly one cycle.
REQ-016 SHALL sample len_i and repeat_i on the accepted start_i cycle. Later changes to either input SHALL NOT affect the run.
REQ-017 SHALL ignore start_i while busy_o=1.
REQ-018 SHALL treat start_i with len_i=0 or repeat_i=0 as an empty run: no serial activity, and done_o pulses in the next cycle.
REQ-019 SHALL transmit bytes 0..len-1 in address order, then wrap to byte 0 for each subsequent pass, for repeat passes in total.
REQ-020 SHALL frame each byte as 8N1: start bit 0, data LSB first, stop bit 1. Each bit lasts exactly CLKS_PER_BIT cycles.
REQ-021 SHALL drive bytes back to back with no idle gap. NEXT SHALL be merged so that no extra bit time is inserted; each byte occupies exactly 10*CLKS_PER_BIT cycles.
REQ-022 SHALL start the first start bit in the cycle after start_i is accepted. busy_o SHALL be high from that cycle through the final stop bit.
REQ-023 SHALL pulse done_o for one cycle, in the cycle after the final stop bit, with busy_o=0 in that cycle.
REQ-024 SHALL saturate len at MEM_BYTES when len_i > MEM_BYTES.

Reset
REQ-025 SHALL, on rst_i=1, set state=IDLE, uart_tx_o=1, busy_o=0, done_o=0, and clear all counters and the shift register.
REQ-026 SHALL, on rst_i during a run, abort immediately: the line goes high the next cycle and no done_o pulse is produced.
REQ-027 SHALL leave image memory contents unchanged on reset.

Configuration
REQ-028 SHALL, when RUNNER_CHECKSUM_EN is defined, add output checksum_o (8 bits). It is cleared on start accept and on reset, and adds each byte modulo 256 when that byte's start bit begins. Its value is stable from done_o until the next start.
REQ-029 SHALL, when RUNNER_CHECKSUM_EN is undefined, omit the checksum_o port and its logic entirely.

Structure
REQ-030 SHALL place the state enum (IDLE, SEND, NEXT, DONE) and the UART frame constants (10 bits per frame, 8 data bits) in shared package config_pkg.
REQ-031 SHALL implement the serializer as a single sub-module uart_tx with ports clk_i, rst_i, valid_i, data_i[7:0], ready_o, tx_o. The runner SHALL hold only sequencing and memory.

Verification
REQ-032 Reset test: rst_i for 2 cycles -> uart_tx_o=1, busy_o=0, done_o=0.
REQ-033 Single-byte test: CLKS_PER_BIT=4, mem[0]=0xA5, len=1, repeat=1, start -> line reads 0,1,0,1,0,0,1,0,1,1 (each bit 4 cycles); done_o pulses 41 cycles after start.
REQ-034 Repeat test: mem={0x01,0x02,0x03}, len=3, repeat=2 -> bytes 01 02 03 01 02 03 with no gaps; busy_o high for exactly 240 cycles; with RUNNER_CHECKSUM_EN, checksum_o=0x0C.
REQ-035 Empty-run test: len=0, repeat=5, start -> done_o the next cycle; uart_tx_o stays 1.
REQ-036 Ignored-input test: start_i and mem_we_i pulsed mid-run (write 0xFF to addr 0) -> the run is unaffected and mem[0] is unchanged.
REQ-037 Abort test: rst_i mid-byte -> uart_tx_o=1 next cycle and no done_o pulse; a subsequent run completes normally.

Source files
------------

// File: rtl/config_pkg.sv
// Shared definitions for the UART image runner: run-sequencer states and
// the 8N1 frame geometry used by the serializer.
package config_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    NEXT,
    DONE
  } run_state_e;

  localparam int FRAME_BITS = 10;  // start + 8 data + stop
  localparam int DATA_BITS  = 8;

endpackage

// File: rtl/uart_tx.sv
// 8N1 UART serializer. It accepts a byte on valid_i && ready_o and drives
// the start bit in the following cycle. ready_o is also high during the last
// cycle of the stop bit, so a byte offered then continues the line with no
// idle gap.
module uart_tx
  import config_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 valid_i,
  input  logic [DATA_BITS-1:0] data_i,
  output logic                 ready_o,
  output logic                 tx_o
);

  localparam int              CW       = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0]   CLK_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [3:0]      BIT_LAST = 4'(FRAME_BITS - 1);

  logic                 active;
  logic [DATA_BITS:0]   shift_q;   // remaining data bits with the stop bit on top
  logic [CW-1:0]        clk_cnt;
  logic [3:0]           bit_cnt;
  logic                 last_cycle;

  assign last_cycle = active && (clk_cnt == CLK_LAST) && (bit_cnt == BIT_LAST);
  assign ready_o    = !active || last_cycle;

  // Bit timing and shifting; the line is a registered output so it never glitches.
  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values, regardless of statement order.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      active  <= 1'b0;
      tx_o    <= 1'b1;
      shift_q <= '0;
      clk_cnt <= '0;
      bit_cnt <= '0;
    end else if (valid_i && ready_o) begin
      active  <= 1'b1;
      tx_o    <= 1'b0;
      shift_q <= {1'b1, data_i};
      clk_cnt <= '0;
      bit_cnt <= '0;
    end else if (active) begin
      if (clk_cnt == CLK_LAST) begin
        clk_cnt <= '0;
        if (bit_cnt == BIT_LAST) begin
          active <= 1'b0;
          tx_o   <= 1'b1;
        end else begin
          bit_cnt <= bit_cnt + 4'd1;
          tx_o    <= shift_q[0];
          shift_q <= {1'b1, shift_q[DATA_BITS:1]};
        end
      end else begin
        clk_cnt <= clk_cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/picorv_uart_runner.sv
// Byte-image runner: holds a small byte image and streams bytes 0..len-1 over
// a UART, repeated for a number of passes, with no gap between frames.
// Optional feature: define RUNNER_CHECKSUM_EN to add checksum_o, the modulo-256
// sum of every byte sent in the current/last run.
module picorv_uart_runner
  import config_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434,
  parameter int MEM_BYTES    = 256
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         mem_we_i,
  input  logic [$clog2(MEM_BYTES)-1:0] mem_addr_i,
  input  logic [7:0]                   mem_wdata_i,
  input  logic [$clog2(MEM_BYTES):0]   len_i,
  input  logic [7:0]                   repeat_i,
  input  logic                         start_i,
  output logic                         busy_o,
  output logic                         done_o,
  output logic                         uart_tx_o
`ifdef RUNNER_CHECKSUM_EN
  ,
  output logic [7:0]                   checksum_o
`endif
);

  localparam int AW = $clog2(MEM_BYTES);
  localparam int LW = AW + 1;
  localparam int TW = LW + 8;  // wide enough for len * repeat

  logic [7:0]    mem [MEM_BYTES];
  run_state_e    state;
  logic [AW-1:0] idx;       // image address of the next byte to hand to the serializer
  logic [LW-1:0] len_q;
  logic [TW-1:0] left;      // bytes still to be handed over after the current one
  logic [LW-1:0] len_sat;
  logic          run_ok;
  logic [AW-1:0] rd_addr;
  logic [7:0]    tx_data;
  logic          tx_valid;
  logic          tx_ready;

  function automatic logic [AW-1:0] step_idx(input logic [AW-1:0] cur,
                                             input logic [LW-1:0] len);
    return ({1'b0, cur} == len - LW'(1)) ? '0 : cur + AW'(1);
  endfunction

  assign len_sat = (len_i > LW'(MEM_BYTES)) ? LW'(MEM_BYTES) : len_i;
  assign run_ok  = (len_i != '0) && (repeat_i != '0);
  assign rd_addr = (state == IDLE) ? '0 : idx;
  assign tx_data = mem[rd_addr];

  // Image write port; writes are locked out while a run is streaming.
  // NOTE: the image array has no reset so contents survive rst_i and the
  // array can map onto plain RAM.
  always_ff @(posedge clk_i) begin
    if (mem_we_i && !busy_o) begin
      mem[mem_addr_i] <= mem_wdata_i;
    end
  end

  // Offer a byte on run accept, and at the last stop-bit cycle while bytes remain.
  // NOTE: tx_valid gets a default before the case so no latch is inferred.
  always_comb begin
    tx_valid = 1'b0;
    case (state)
      IDLE:    tx_valid = start_i && run_ok;
      SEND:    tx_valid = tx_ready && (left != '0);
      default: tx_valid = 1'b0;
    endcase
  end

  // Run sequencer. NEXT overlaps the start bit of the byte just handed over,
  // so it never adds line time; the final byte goes straight to DONE.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state  <= IDLE;
      busy_o <= 1'b0;
      done_o <= 1'b0;
      idx    <= '0;
      len_q  <= '0;
      left   <= '0;
`ifdef RUNNER_CHECKSUM_EN
      checksum_o <= '0;
`endif
    end else begin
      done_o <= 1'b0;
      case (state)
        IDLE: begin
          if (start_i) begin
            if (run_ok) begin
              state  <= SEND;
              busy_o <= 1'b1;
              len_q  <= len_sat;
              left   <= TW'(len_sat) * TW'(repeat_i) - TW'(1);
              idx    <= step_idx('0, len_sat);
`ifdef RUNNER_CHECKSUM_EN
              checksum_o <= tx_data;
`endif
            end else begin
              state  <= DONE;
              done_o <= 1'b1;
`ifdef RUNNER_CHECKSUM_EN
              checksum_o <= '0;
`endif
            end
          end
        end
        SEND: begin
          if (tx_ready) begin
            if (left != '0) begin
              state <= NEXT;
              idx   <= step_idx(idx, len_q);
`ifdef RUNNER_CHECKSUM_EN
              checksum_o <= checksum_o + tx_data;
`endif
            end else begin
              state  <= DONE;
              busy_o <= 1'b0;
              done_o <= 1'b1;
            end
          end
        end
        NEXT: begin
          left  <= left - TW'(1);
          state <= SEND;
        end
        DONE: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  uart_tx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_uart_tx (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .valid_i(tx_valid),
    .data_i (tx_data),
    .ready_o(tx_ready),
    .tx_o   (uart_tx_o)
  );

endmodule

// File: tb/tb_picorv_uart_runner.sv
// Self-checking bench for picorv_uart_runner. Expected line activity is
// derived from an image model: each pass of each run expands into 8N1 bit
// lists that the sampled line is compared against cycle by cycle.
module tb_picorv_uart_runner;

  localparam int CLKS = 4;
  localparam int MEMB = 16;
  localparam int AW   = $clog2(MEMB);
  localparam int LW   = AW + 1;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          mem_we_i;
  logic [AW-1:0] mem_addr_i;
  logic [7:0]    mem_wdata_i;
  logic [LW-1:0] len_i;
  logic [7:0]    repeat_i;
  logic          start_i;
  logic          busy_o;
  logic          done_o;
  logic          uart_tx_o;
`ifdef RUNNER_CHECKSUM_EN
  logic [7:0]    checksum_o;
`endif

  int         checks = 0;
  int         errors = 0;
  logic [7:0] model_mem [MEMB];
  logic [9:0] last_frame;
  int         last_busy;

  always #5 clk_i = ~clk_i;

  picorv_uart_runner #(
    .CLKS_PER_BIT(CLKS),
    .MEM_BYTES   (MEMB)
  ) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .mem_we_i   (mem_we_i),
    .mem_addr_i (mem_addr_i),
    .mem_wdata_i(mem_wdata_i),
    .len_i      (len_i),
    .repeat_i   (repeat_i),
    .start_i    (start_i),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .uart_tx_o  (uart_tx_o)
`ifdef RUNNER_CHECKSUM_EN
    ,
    .checksum_o (checksum_o)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic write_mem(input int addr, input logic [7:0] data);
    mem_we_i    = 1'b1;
    mem_addr_i  = AW'(addr);
    mem_wdata_i = data;
    @(posedge clk_i); #1;
    mem_we_i    = 1'b0;
    model_mem[addr] = data;
  endtask

  // Start a run and compare the whole line against the model. When inj > 0,
  // start_i and a write of 0xFF to address 0 are pulsed at that run cycle.
  task automatic run_check(input string tag, input int len, input int rep, input int inj);
    logic       exp_bits [$];
    logic [9:0] obs;
    logic [9:0] ef;
    logic [7:0] b;
    logic [7:0] sum;
    int eff, total, bad, busy_cnt, byte_no;
    eff = (len > MEMB) ? MEMB : len;
    sum = 8'h00;
    exp_bits.delete();
    for (int p = 0; p < rep; p++) begin
      for (int i = 0; i < eff; i++) begin
        b = model_mem[i];
        sum = sum + b;
        exp_bits.push_back(1'b0);
        for (int k = 0; k < 8; k++) exp_bits.push_back(b[k]);
        exp_bits.push_back(1'b1);
      end
    end
    total    = exp_bits.size() * CLKS;
    bad      = 0;
    busy_cnt = 0;
    obs      = '0;

    len_i    = LW'(len);
    repeat_i = 8'(rep);
    start_i  = 1'b1;
    @(posedge clk_i); #1;
    start_i  = 1'b0;
    len_i    = LW'($urandom);
    repeat_i = 8'($urandom);

    for (int c = 0; c < total; c++) begin
      @(negedge clk_i);
      if (inj > 0 && c == inj) begin
        start_i     = 1'b1;
        mem_we_i    = 1'b1;
        mem_addr_i  = '0;
        mem_wdata_i = 8'hFF;
      end else if (inj > 0 && c == inj + 1) begin
        start_i  = 1'b0;
        mem_we_i = 1'b0;
      end
      if (uart_tx_o !== exp_bits[c / CLKS]) bad++;
      if (done_o !== 1'b0) bad++;
      if (busy_o === 1'b1) busy_cnt++;
      if (c % CLKS == CLKS / 2) obs[(c / CLKS) % 10] = uart_tx_o;
      if (c % CLKS == CLKS - 1 && (c / CLKS) % 10 == 9) begin
        byte_no = c / (CLKS * 10);
        for (int k = 0; k < 10; k++) ef[k] = exp_bits[byte_no * 10 + k];
        check($sformatf("%s_frame%0d", tag, byte_no), 32'(obs), 32'(ef));
        last_frame = obs;
      end
    end
    start_i  = 1'b0;
    mem_we_i = 1'b0;
    check({tag, "_line_cycles"}, 32'(bad), 32'd0);
    check({tag, "_busy_cycles"}, 32'(busy_cnt), 32'(total));
    last_busy = busy_cnt;

    @(negedge clk_i);
    check({tag, "_done_pulse"}, 32'(done_o), 32'd1);
    check({tag, "_done_busy"},  32'(busy_o), 32'd0);
    check({tag, "_done_line"},  32'(uart_tx_o), 32'd1);
`ifdef RUNNER_CHECKSUM_EN
    check({tag, "_checksum"}, 32'(checksum_o), 32'(sum));
`endif
    @(negedge clk_i);
    check({tag, "_done_single"}, 32'(done_o), 32'd0);
    check({tag, "_idle_line"},   32'(uart_tx_o), 32'd1);
  endtask

  initial begin
    int pulses;
    int line_bad;
    rst_i       = 1'b1;
    mem_we_i    = 1'b0;
    mem_addr_i  = '0;
    mem_wdata_i = 8'h00;
    len_i       = '0;
    repeat_i    = 8'h00;
    start_i     = 1'b0;
    for (int i = 0; i < MEMB; i++) model_mem[i] = 8'h00;

    // Reset held for two cycles.
    repeat (2) @(posedge clk_i);
    #1 rst_i = 1'b0;
    @(negedge clk_i);
    check("reset_line", 32'(uart_tx_o), 32'd1);
    check("reset_busy", 32'(busy_o), 32'd0);
    check("reset_done", 32'(done_o), 32'd0);

    // Clear the image so the model matches regardless of power-up contents.
    @(posedge clk_i); #1;
    for (int i = 0; i < MEMB; i++) write_mem(i, 8'h00);

    // Single byte 0xA5: line 0,1,0,1,0,0,1,0,1,1, done 41 cycles after start.
    write_mem(0, 8'hA5);
    run_check("single", 1, 1, 0);
    check("single_a5_pattern", 32'(last_frame), 32'h34A);

    // Three bytes, two passes, back to back.
    write_mem(0, 8'h01);
    write_mem(1, 8'h02);
    write_mem(2, 8'h03);
    run_check("repeat", 3, 2, 0);
    check("repeat_busy_240", 32'(last_busy), 32'd240);

    // Empty runs: immediate done, line idle.
    run_check("empty_len0", 0, 5, 0);
    run_check("empty_rep0", 3, 0, 0);

    // start_i and a write pulsed mid-run are ignored; image byte 0 stays 0x01.
    run_check("ignored", 3, 1, 50);
    run_check("ignored_after", 1, 1, 0);
    check("ignored_mem0", 32'(last_frame), 32'({1'b1, 8'h01, 1'b0}));

    // Abort in the middle of a byte whose bits are all zero.
    write_mem(0, 8'h00);
    write_mem(1, 8'h00);
    len_i    = LW'(2);
    repeat_i = 8'd1;
    start_i  = 1'b1;
    @(posedge clk_i); #1;
    start_i  = 1'b0;
    repeat (14) @(negedge clk_i);
    check("abort_line_low", 32'(uart_tx_o), 32'd0);
    check("abort_busy_run", 32'(busy_o), 32'd1);
    rst_i = 1'b1;
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    @(negedge clk_i);
    check("abort_line_high", 32'(uart_tx_o), 32'd1);
    check("abort_busy_low",  32'(busy_o), 32'd0);
    pulses   = 0;
    line_bad = 0;
    repeat (120) begin
      @(negedge clk_i);
      if (done_o === 1'b1) pulses++;
      if (uart_tx_o !== 1'b1) line_bad++;
    end
    check("abort_no_done", 32'(pulses), 32'd0);
    check("abort_line_idle", 32'(line_bad), 32'd0);
    write_mem(0, 8'h5C);
    write_mem(1, 8'hC3);
    run_check("after_abort", 2, 1, 0);

    // Random image and runs, including lengths above the image size.
    for (int i = 0; i < MEMB; i++) write_mem(i, 8'($urandom));
    run_check("saturate", MEMB + 4, 1, 0);
    for (int r = 0; r < 4; r++) begin
      run_check($sformatf("rand%0d", r), $urandom_range(1, MEMB + 4), $urandom_range(1, 3), 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
